or_reduce_pipe: RTL
===================

// Module: or_reduce_pipe
// PURPOSE
// - Parametrised, pipelined N-input OR reduction with valid/ready flow control and a sticky accumulator.
// - Generalises the 2-input OR to WIDTH inputs; an optional mode inverts the output to NOR.
// - Used as the zero/any-set flag path for wide ALU and bus words, e.g. the zr flag, Or8Way and Or16 uses.
// - The accumulator gives a multi-beat "any bit ever set" flag for test and debug sequencing.
// PARAMETERS
// - WIDTH         16  number of input bits; legal range >= 2.
// - STAGE_LEVELS  2   OR-tree levels between pipeline registers; legal range >= 1.
// - INVERT        0   1 makes out_bit = NOR; acc_bit is never inverted.
// PORTS
// - clk       in   1      single clock; all state updates on its rising edge.
// - rst_n     in   1      reset, asynchronous and active-low.
// - in_valid  in   1      in_data/in_acc hold a beat.
// - in_ready  out  1      the block accepts a beat this cycle.
// - in_data   in   WIDTH  word to reduce.
// - in_acc    in   1      the beat also ORs into acc_bit when it leaves the pipe.
// - clear     in   1      synchronous clear of acc_bit.
// - out_valid out  1      out_bit holds a result.
// - out_ready in   1      the consumer takes the result.
// - out_bit   out  1      |in_data of the beat, or ~| when INVERT=1.
// - acc_bit   out  1      sticky OR of all tagged beats since the last clear or reset.
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - While rst_n=0: all stage valids=0, out_valid=0, out_bit=0, acc_bit=0, in_ready=0.
//   - in_ready rises on the first clk edge after deassertion.
// - LEVELS = clog2(WIDTH).
// - Latency L = max(1, ceil(LEVELS/STAGE_LEVELS)) cycles, from accept to out_valid; the output is always registered.
//   - WIDTH=16, STAGE_LEVELS=2: L=2.
//   - WIDTH=5: LEVELS=3; with STAGE_LEVELS=2, L=2.
// - Tree: pairwise OR per level. An odd leftover bit passes through to the next level unchanged.
//   - Never pad with 1; padding with 0 is legal.
// - Flow control is a global stall.
//   - adv = ~out_valid | out_ready.
//   - in_ready = adv after reset.
//   - When adv=1, every stage register and its valid/acc tag shifts one place; otherwise all stages hold.
// - Accept = in_valid & in_ready.
//   - When in_ready=1 and in_valid=0, a bubble (valid=0) enters the pipe.
// - Throughput: one beat per cycle while out_ready=1.
// - Output beats appear in acceptance order; none are dropped or duplicated.
// - out_bit/out_valid stay stable while out_valid & ~out_ready.
// - Output handshake H = out_valid & out_ready.
// - Accumulator update, per rising edge:
//   - clear=1 & H & tag=1: acc_bit <= raw OR of the departing beat. clear wins over the old value, the new beat still counts.
//   - clear=1 otherwise: acc_bit <= 0.
//   - clear=0 & H & tag=1: acc_bit <= acc_bit | raw OR.
//   - else: hold.
//   - Here tag = in_acc sampled at acceptance, and raw OR is the value before INVERT.
// - in_data is don't-care when in_valid=0; it must not affect any state.
// - Reset asserted mid-operation: all in-flight beats and acc_bit are discarded; no partial output.
// STRUCTURE
// - Shared include n2t_defs.vh:
//   - clog2 constant function.
//   - Stage-count macro N2T_STAGES(levels, per_stage).
// - Sub-module or_tree_slice (combinational): parameters IN_W and LEVELS.
//   - Reduces IN_W bits through LEVELS pairwise levels to ceil(IN_W/2^LEVELS) bits.
//   - Built from or_gate instances, so the gate-level lineage is preserved.
// - Top: generate loop of L slices plus a register ring {data, valid, acc_tag}; one acc_bit flop; INVERT mux on output.
// TESTING
// - Reset: hold rst_n=0 while driving in_valid=1 -> out_valid=0, acc_bit=0, in_ready=0.
//   - After release: first accepted beat appears L=2 cycles later.
// - Streaming: WIDTH=16, out_ready=1, beats 16'h0000, 16'h8000, 16'h0001, 16'h0000.
//   - Expect out_bit 0,1,1,0 on consecutive cycles starting at cycle 2.
//   - INVERT=1 build gives 1,0,0,1.
// - Backpressure: out_ready=0 for 3 cycles with the pipe full.
//   - in_ready=0, and out_bit holds its value.
//   - Release: the beats drain in order with no loss.
// - Accumulator: tagged beats 0x0000 then 0x0400 then 0x0000 -> acc_bit 0, 0, 1, stays 1.
//   - clear with a simultaneous tagged 0x0000 handshake -> acc_bit=0.
//   - clear with a simultaneous tagged 0x0002 handshake -> acc_bit=1.
// - Odd width: WIDTH=5, STAGE_LEVELS=1 (L=3).
//   - Sweep all 32 inputs -> out_bit=0 only for 5'b00000.
//   - Latency is exactly 3 cycles.
// - Mid-operation reset: two beats in flight, pulse rst_n low for 1ns between edges.
//   - out_valid drops immediately; no beat emerges after release.

Source files
------------

// File: rtl/or_reduce_pipe_pkg.sv
// Shared constant helpers for the pipelined OR reduction: tree depth,
// stage count, and per-stage word widths.
package or_reduce_pipe_pkg;

   function automatic int clog2(input int v);
      for (int r = 0; r < 31; r++)
         if ((1 << r) >= v) return r;
      return 31;
   endfunction

   // Stage count, never below one so the output is always registered.
   function automatic int n2t_stages(input int levels, input int per_stage);
      int s;
      s = (levels + per_stage - 1) / per_stage;
      return (s < 1) ? 1 : s;
   endfunction

   function automatic int ceil_shr(input int w, input int n);
      return (w + (1 << n) - 1) >> n;
   endfunction

   function automatic int stage_lv(input int per_stage, input int levels, input int k);
      int rem;
      rem = levels - k * per_stage;
      if (rem <= 0) return 0;
      return (rem < per_stage) ? rem : per_stage;
   endfunction

   // Word width entering stage k (k = stage count gives the final width).
   function automatic int stage_w(input int width, input int per_stage, input int levels,
                                  input int k);
      int done;
      done = k * per_stage;
      if (done > levels) done = levels;
      return ceil_shr(width, done);
   endfunction

endpackage

// File: rtl/or_reduce_pipe_if.sv
// Beat-in / flag-out bus for or_reduce_pipe.
interface or_reduce_pipe_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_acc;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic             acc_bit;

   modport master (
      output in_valid, in_data, in_acc, clear, out_ready,
      input  in_ready, out_valid, out_bit, acc_bit
   );

   modport slave (
      input  in_valid, in_data, in_acc, clear, out_ready,
      output in_ready, out_valid, out_bit, acc_bit
   );
endinterface

// File: rtl/or_reduce_pipe_or_tree_slice.sv
// Combinational slice of the OR tree: LEVELS pairwise levels built from
// or_gate cells; an odd leftover bit passes straight to the next level.
module or_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module or_tree_slice
   import or_reduce_pipe_pkg::*;
#(
   parameter int IN_W   = 4,
   parameter int LEVELS = 1
) (
   input  logic [IN_W-1:0]                   in_bits,
   output logic [ceil_shr(IN_W, LEVELS)-1:0] out_bits
);
   for (genvar j = 0; j <= LEVELS; j++) begin : g_lvl
      localparam int W = ceil_shr(IN_W, j);
      logic [W-1:0] n;
      if (j == 0) begin : g_src
         assign n = in_bits;
      end else begin : g_red
         localparam int PW = ceil_shr(IN_W, j - 1);
         for (genvar i = 0; i < W; i++) begin : g_bit
            if (2 * i + 1 < PW) begin : g_pair
               or_gate u_or (.a(g_lvl[j-1].n[2*i]), .b(g_lvl[j-1].n[2*i+1]), .y(n[i]));
            end else begin : g_pass
               assign n[i] = g_lvl[j-1].n[2*i];
            end
         end
      end
   end

   assign out_bits = g_lvl[LEVELS].n;
endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined WIDTH-input OR/NOR reduction with a global-stall valid/ready
// pipe and a sticky "any tagged bit ever set" accumulator.
module or_reduce_pipe
   import or_reduce_pipe_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int STAGE_LEVELS = 2,
   parameter bit INVERT       = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   or_reduce_pipe_if.slave bus
);
   localparam int LEVELS = clog2(WIDTH);
   localparam int L      = n2t_stages(LEVELS, STAGE_LEVELS);

   logic         run_q;
   logic         adv, accept, hs, raw, acc_q;
   logic [L:1]   vld_pipe, tag_pipe;

   assign adv    = ~vld_pipe[L] | bus.out_ready;
   assign accept = bus.in_valid & bus.in_ready;
   assign hs     = vld_pipe[L] & bus.out_ready;

   // in_ready stays low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else if (adv) begin
         vld_pipe <= L'({vld_pipe, accept});
         tag_pipe <= L'({tag_pipe, accept & bus.in_acc});
      end

   for (genvar k = 0; k < L; k++) begin : g_stage
      localparam int IW = stage_w(WIDTH, STAGE_LEVELS, LEVELS, k);
      localparam int OW = stage_w(WIDTH, STAGE_LEVELS, LEVELS, k + 1);
      localparam int LV = stage_lv(STAGE_LEVELS, LEVELS, k);
      logic [IW-1:0] d;
      logic [OW-1:0] r, q;
      if (k == 0) begin : g_head
         // Bubbles enter as zero so idle in_data never reaches state.
         assign d = accept ? bus.in_data : '0;
      end else begin : g_body
         assign d = g_stage[k-1].q;
      end
      or_tree_slice #(.IN_W(IW), .LEVELS(LV)) u_slice (.in_bits(d), .out_bits(r));
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n)   q <= '0;
         else if (adv) q <= r;
   end

   assign raw = g_stage[L-1].q[0];

   // clear beats the old value but the departing tagged beat still counts.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                  acc_q <= 1'b0;
      else if (bus.clear)          acc_q <= hs & tag_pipe[L] & raw;
      else if (hs & tag_pipe[L])   acc_q <= acc_q | raw;

   assign bus.in_ready  = run_q & adv;
   assign bus.out_valid = vld_pipe[L];
   assign bus.out_bit   = vld_pipe[L] & (raw ^ INVERT);
   assign bus.acc_bit   = acc_q;
endmodule
